// File: rtl/hard_limiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hard_limiter_pkg : shared types and error codes for the hard limiter |
// | Revision 2.0                                                         |
// +----------------------------------------------------------------------+
package hard_limiter_pkg;

   typedef enum logic [1:0] {
      BYPASS = 2'd0,
      CLAMP  = 2'd1,
      FLAG   = 2'd2,
      RSVD   = 2'd3
   } LIMIT_MODE_T;

   typedef enum logic [1:0] {
      INBOUND   = 2'd0,
      BELOW_MIN = 2'd1,
      ABOVE_MAX = 2'd2,
      INVALID   = 2'd3
   } SIGNAL_CASE_T;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } SKID_STATE_T;

   localparam logic [1:0] ERR_NONE        = 2'b00;
   localparam logic [1:0] ERR_LIMIT_FAULT = 2'b11;

endpackage
`default_nettype wire

// File: rtl/hl_skid_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hl_skid_buffer : 2-entry output skid buffer, head entry drives out   |
// | Revision 2.0                                                         |
// +----------------------------------------------------------------------+
module hl_skid_buffer #(
   parameter int PAYLOAD_W = 18
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 push,
   input  logic [PAYLOAD_W-1:0] push_data,
   output logic                 space,
   output logic                 out_valid,
   output logic [PAYLOAD_W-1:0] out_data,
   input  logic                 out_ready
);
   import hard_limiter_pkg::*;

   SKID_STATE_T          state_q, state_d;
   logic [PAYLOAD_W-1:0] head_q, head_d;
   logic [PAYLOAD_W-1:0] tail_q, tail_d;
   logic                 w_pop;

   assign w_pop     = (state_q != EMPTY) && out_ready;
   assign space     = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = head_q;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               state_d = ONE;
               head_d  = push_data;
            end
         end
         ONE: begin
            if (push && w_pop) begin
               head_d = push_data;
            end else if (push) begin
               state_d = FULL;
               tail_d  = push_data;
            end else if (w_pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // Upstream is stalled here, so only a pop can move the buffer.
            if (w_pop) begin
               state_d = ONE;
               head_d  = tail_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/hard_limiter_v2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hard_limiter_v2 : mode-selectable sample limiter with clip stats     |
// | Revision 2.0                                                         |
// +----------------------------------------------------------------------+
module hard_limiter_v2 #(
   parameter int DATA_W       = 16,
   parameter int CNT_W        = 16,
   parameter int MODE_DEFAULT = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [2*DATA_W-1:0]   limbuff_data,
   input  logic                  limbuff_valid,
   input  logic                  iter_input_enable,
   input  logic [1:0]            mode_in,
   input  logic                  mode_load,
   input  logic [DATA_W-1:0]     fir_data,
   input  logic                  fir_valid,
   input  logic [1:0]            fir_error,
   output logic                  fir_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_valid,
   output logic [1:0]            out_error,
   input  logic                  out_ready,
   input  logic                  cnt_clear,
   output logic [CNT_W-1:0]      clip_below_cnt,
   output logic [CNT_W-1:0]      clip_above_cnt,
   output logic                  limit_fault
);
   import hard_limiter_pkg::*;

   localparam int               PAYLOAD_W = DATA_W + 2;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam LIMIT_MODE_T      MODE_RST  = LIMIT_MODE_T'(MODE_DEFAULT[1:0]);

   LIMIT_MODE_T              mode_q, mode_d;
   logic [CNT_W-1:0]         below_cnt_q, below_cnt_d;
   logic [CNT_W-1:0]         above_cnt_q, above_cnt_d;
   logic                     limit_fault_q, limit_fault_d;

   logic signed [DATA_W-1:0] w_max, w_min, w_sample, w_data;
   logic [1:0]               w_error, w_flag;
   SIGNAL_CASE_T             w_case;
   logic                     w_space, w_accept, w_count;
   logic [PAYLOAD_W-1:0]     w_out_payload;

   assign w_max    = limbuff_data[2*DATA_W-1:DATA_W];
   assign w_min    = limbuff_data[DATA_W-1:0];
   assign w_sample = fir_data;

   assign fir_ready = w_space & limbuff_valid & iter_input_enable & ~reset;
   assign w_accept  = fir_valid & fir_ready;

   always_comb begin
      if (w_min > w_max)         w_case = INVALID;
      else if (w_sample < w_min) w_case = BELOW_MIN;
      else if (w_sample > w_max) w_case = ABOVE_MAX;
      else                       w_case = INBOUND;
   end

   always_comb begin
      w_data  = w_sample;
      w_error = fir_error;
      case (w_case)
         BELOW_MIN: w_flag = 2'b01;
         ABOVE_MAX: w_flag = 2'b10;
         default:   w_flag = ERR_NONE;
      endcase
      if (w_case == INVALID) begin
         w_error = ERR_LIMIT_FAULT;
      end else begin
         case (mode_q)
            BYPASS:  w_error = fir_error;
            FLAG:    w_error = fir_error | w_flag;
            default: begin
               if (w_case == BELOW_MIN)      w_data = w_min;
               else if (w_case == ABOVE_MAX) w_data = w_max;
            end
         endcase
      end
   end

   always_comb begin
      mode_d        = mode_load ? LIMIT_MODE_T'(mode_in) : mode_q;
      below_cnt_d   = below_cnt_q;
      above_cnt_d   = above_cnt_q;
      limit_fault_d = limit_fault_q;
      w_count       = w_accept && (mode_q != BYPASS);
      if (w_accept && (w_case == INVALID))
         limit_fault_d = 1'b1;
      if (w_count && (w_case == BELOW_MIN) && (below_cnt_q != CNT_MAX))
         below_cnt_d = below_cnt_q + CNT_W'(1);
      if (w_count && (w_case == ABOVE_MAX) && (above_cnt_q != CNT_MAX))
         above_cnt_d = above_cnt_q + CNT_W'(1);
      // Clear wins over a same-cycle increment or fault.
      if (cnt_clear) begin
         below_cnt_d   = '0;
         above_cnt_d   = '0;
         limit_fault_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mode_q        <= MODE_RST;
         below_cnt_q   <= '0;
         above_cnt_q   <= '0;
         limit_fault_q <= 1'b0;
      end else begin
         mode_q        <= mode_d;
         below_cnt_q   <= below_cnt_d;
         above_cnt_q   <= above_cnt_d;
         limit_fault_q <= limit_fault_d;
      end
   end

   hl_skid_buffer #(
      .PAYLOAD_W (PAYLOAD_W)
   ) u_skid (
      .clock     (clock),
      .reset     (reset),
      .push      (w_accept),
      .push_data ({w_error, w_data}),
      .space     (w_space),
      .out_valid (out_valid),
      .out_data  (w_out_payload),
      .out_ready (out_ready)
   );

   assign out_data       = w_out_payload[DATA_W-1:0];
   assign out_error      = w_out_payload[PAYLOAD_W-1:DATA_W];
   assign clip_below_cnt = below_cnt_q;
   assign clip_above_cnt = above_cnt_q;
   assign limit_fault    = limit_fault_q;

endmodule
`default_nettype wire

// File: doc/hard_limiter_v2.md
Name: hard_limiter_v2

Overview:
- Parametrised successor to the single-sample hard limiter in the reconstruction loop. It sits between the FIR filter output and the next iteration stage.
- Clamps each filtered sample to the current {max,min} pair from the limits buffer controller. Mode is selectable: bypass, clamp, or flag-only.
- Adds a real valid/ready path via a 2-entry output skid buffer, so fir_ready no longer depends combinationally on out_ready.
- Adds saturating clip statistics and a sticky fault flag for inverted limits.

Parameters:
- DATA_W, 16, signed sample width; limbuff_data is 2*DATA_W wide.
- CNT_W, 16, width of each clip counter.
- MODE_DEFAULT, 1, mode used after reset until mode_load (0 BYPASS, 1 CLAMP, 2 FLAG).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- limbuff_data  in  2*DATA_W  [2*DATA_W-1:DATA_W] = max, [DATA_W-1:0] = min, both signed.
- limbuff_valid  in  1  limits pair is valid.
- iter_input_enable  in  1  iteration controller allows sample intake.
- mode_in  in  2  requested mode.
- mode_load  in  1  latch mode_in into the mode register.
- fir_data  in  DATA_W  signed sample.
- fir_valid  in  1  sample valid.
- fir_error  in  2  upstream error code.
- fir_ready  out  1  block can accept a sample.
- out_data  out  DATA_W  limited sample.
- out_valid  out  1  output valid.
- out_error  out  2  output error code.
- out_ready  in  1  downstream ready.
- cnt_clear  in  1  synchronous clear of the counters and limit_fault.
- clip_below_cnt  out  CNT_W  number of accepted samples below min.
- clip_above_cnt  out  CNT_W  number of accepted samples above max.
- limit_fault  out  1  sticky flag: min > max was seen on an accepted sample.

Behaviour:
- This design uses one clock, and reset is synchronous and active-high. Port names are clock and reset.
- Reset values:
  - out_valid = 0, out_data = 0, out_error = 0.
  - fir_ready = 0 during the reset cycle.
  - both counters = 0, limit_fault = 0.
  - mode = MODE_DEFAULT.
  - skid buffer = EMPTY.
- Intake:
  - fir_ready = (buffer != FULL) & limbuff_valid & iter_input_enable & ~reset.
  - fir_ready must not depend on fir_valid or out_ready.
  - accept = fir_valid & fir_ready.
- Compare (signed):
  - below = fir_data < min; above = fir_data > max.
  - Equality with either limit counts as inbound.
  - inverted = min > max.
- Per accepted sample, in priority order:
  - inverted: data = fir_data, error = 2'b11, limit_fault set, counters unchanged.
  - BYPASS: data = fir_data, error = fir_error, no counting.
  - CLAMP: data = min if below, max if above, otherwise fir_data; error = fir_error; the matching counter increments.
  - FLAG: data = fir_data; error = fir_error | {above, below}; the matching counter increments.
  - mode values 3 behave as CLAMP.
- Latency: an accepted sample appears on out_* the next cycle when the buffer is empty.
- Mode changes take effect for samples accepted the cycle after mode_load. Samples already buffered are not altered.
- Skid buffer FSM (states EMPTY, ONE, FULL):
  - EMPTY: accept -> ONE.
  - ONE: accept & ~pop -> FULL; pop & ~accept -> EMPTY; accept & pop -> ONE (head replaced).
  - FULL: pop -> ONE; accept is impossible because fir_ready = 0.
  - pop = out_valid & out_ready.
  - out_valid = (state != EMPTY). out_data and out_error come from the head entry and are held stable while out_valid & ~out_ready.
- Counters:
  - saturate at 2^CNT_W-1 with no wrap.
  - cnt_clear has priority over a same-cycle increment (result 0) and also clears limit_fault.
- Reset mid-operation flushes both buffer entries; out_valid is 0 in the cycle after reset asserts. Samples in flight are dropped and not counted.
- limbuff_valid or iter_input_enable falling only blocks intake; buffered samples continue to drain.

Decomposition:
- Package hard_limiter_pkg:
  - LIMIT_MODE_T enum (BYPASS, CLAMP, FLAG, RSVD).
  - SIGNAL_CASE_T (INBOUND, BELOW_MIN, ABOVE_MAX, INVALID).
  - SKID_STATE_T (EMPTY, ONE, FULL).
  - error code constants ERR_NONE = 2'b00 and ERR_LIMIT_FAULT = 2'b11.
- Sub-module hl_skid_buffer, parametrised on payload width (DATA_W+2). It owns the FSM, both entries, fir_ready's space term, and out_valid.

Test Plan:
- DATA_W=16, CLAMP, limits {max=1000, min=-1000}, inputs 500, -2000, 3000, 1000, -1000 with out_ready=1 -> out 500, -1000, 1000, 1000, -1000, each one cycle after accept; below_cnt=1, above_cnt=1.
- Backpressure: out_ready=0 while 3 samples are offered -> 2 accepted, fir_ready=0 on the third, out_data stable. out_ready=1 -> drains in order, third accepted, no loss or duplication.
- FLAG mode, fir_error=2'b00, inputs 2000 and -2000 -> data unchanged, out_error 2'b10 and 2'b01. BYPASS with the same inputs -> out_error 2'b00, counters unchanged.
- Inverted limits {max=-5, min=5}, input 0 -> out_data 0, out_error 2'b11, limit_fault=1 and held; cnt_clear -> limit_fault=0.
- CNT_W=2, five above-max samples -> above_cnt saturates at 3. cnt_clear in the same cycle as an increment -> 0.
- Reset asserted with the buffer FULL -> next cycle out_valid=0, counters 0, mode=MODE_DEFAULT. iter_input_enable=0 -> fir_ready=0 while the buffer still drains.
